// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: performs one load or store through a
// variable-latency data-memory handshake, then issues a single register-file write.
module mem_wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  dst_reg,
    input  logic        ctrl_regwrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  wr_reg,
    output logic [31:0] wr_dat,
    output logic        RegWrite,
    output logic        align_err
);

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_WB} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, sdata_q;
    logic [4:0]  dst_q;
    logic        regwrite_q, rd_q, wr_q, uns_q;
    logic [1:0]  size_q;

    logic [4:0]  wr_reg_q, wr_reg_d;
    logic [31:0] wr_dat_q, wr_dat_d;
    logic        regwrite_out_q, regwrite_out_d;
    logic        align_q, align_d;

    logic accept, in_misal, in_mem, in_mem_st, mem_done;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            default: return (a != 2'b00);
        endcase
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] rdata, input logic [1:0] a,
                                                 input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = a[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [31:0] d, input logic [1:0] size);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] a, input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    assign in_ready  = (state_q != S_MEM);
    assign accept    = in_valid && in_ready;
    assign in_misal  = (MemRead || MemWrite) && misaligned(mem_size, alu_result[1:0]);
    assign in_mem    = (MemRead || MemWrite) && !in_misal;
    assign in_mem_st = (state_q == S_MEM);
    assign mem_done  = in_mem_st && dmem_ack;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_MEM:   if (dmem_ack) state_d = S_WB;
            default: begin
                if (accept) state_d = in_mem ? S_MEM : S_WB;
                else        state_d = S_IDLE;
            end
        endcase
    end

    // Write-back fields are registered on the edge that enters WB, so they are
    // presented for exactly that one cycle and then hold (only RegWrite drops).
    always_comb begin
        wr_reg_d       = wr_reg_q;
        wr_dat_d       = wr_dat_q;
        regwrite_out_d = 1'b0;
        align_d        = 1'b0;
        if (mem_done) begin
            wr_reg_d       = dst_q;
            wr_dat_d       = (rd_q && !wr_q) ? extract_load(dmem_rdata, addr_q[1:0], size_q, uns_q)
                                             : addr_q;
            regwrite_out_d = regwrite_q && (dst_q != 5'd0) && !wr_q;
        end else if (accept && !in_mem) begin
            wr_reg_d       = dst_reg;
            wr_dat_d       = alu_result;
            regwrite_out_d = ctrl_regwrite && (dst_reg != 5'd0) && !MemWrite && !in_misal;
            align_d        = in_misal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            wr_reg_q       <= '0;
            wr_dat_q       <= '0;
            regwrite_out_q <= 1'b0;
            align_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_reg_q       <= wr_reg_d;
            wr_dat_q       <= wr_dat_d;
            regwrite_out_q <= regwrite_out_d;
            align_q        <= align_d;
        end
    end

    // Instruction operands only matter while in MEM; outputs are gated by state.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q     <= alu_result;
            sdata_q    <= store_data;
            dst_q      <= dst_reg;
            regwrite_q <= ctrl_regwrite;
            rd_q       <= MemRead;
            wr_q       <= MemWrite;
            size_q     <= mem_size;
            uns_q      <= mem_unsigned;
        end
    end

    assign dmem_req   = in_mem_st;
    assign dmem_we    = in_mem_st && wr_q;
    assign dmem_addr  = in_mem_st ? {addr_q[31:2], 2'b00} : 32'd0;
    assign dmem_wdata = (in_mem_st && wr_q) ? store_wdata(sdata_q, size_q) : 32'd0;
    assign dmem_be    = in_mem_st ? store_be(addr_q[1:0], size_q) : 4'd0;

    assign wr_reg    = wr_reg_q;
    assign wr_dat    = wr_dat_q;
    assign RegWrite  = regwrite_out_q;
    assign align_err = align_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed and randomized transaction checks of mem_wb_stage against a
// transaction-level reference model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result, store_data;
    logic [4:0]  dst_reg;
    logic        ctrl_regwrite, MemRead, MemWrite;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [4:0]  wr_reg;
    logic [31:0] wr_dat;
    logic        RegWrite, align_err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .store_data(store_data), .dst_reg(dst_reg),
        .ctrl_regwrite(ctrl_regwrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .wr_reg(wr_reg), .wr_dat(wr_dat),
        .RegWrite(RegWrite), .align_err(align_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: plain arithmetic on the access rules.
    function automatic logic m_misal(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (!uns && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2'd1) begin
            v = (rd >> (8 * (a & 32'd2))) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [1:0] sz);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_be(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd0) return 32'd1 << (a % 4);
        if (sz == 2'd1) return ((a & 32'd2) != 0) ? 32'd12 : 32'd3;
        return 32'd15;
    endfunction

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic rw, input logic [4:0] dst, input logic [31:0] alu,
                         input logic [31:0] sd);
        in_valid = 1'b1; MemRead = rd; MemWrite = wr; mem_size = sz; mem_unsigned = uns;
        ctrl_regwrite = rw; dst_reg = dst; alu_result = alu; store_data = sd;
    endtask

    task automatic scramble_inputs();
        in_valid = 1'b0; alu_result = $urandom; store_data = $urandom;
        dst_reg = 5'($urandom); mem_size = 2'($urandom); mem_unsigned = 1'($urandom);
        MemRead = 1'($urandom); MemWrite = 1'($urandom); ctrl_regwrite = 1'($urandom);
    endtask

    // Called at a negedge with the stage idle; leaves at a negedge, idle again.
    task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic rw, input logic [4:0] dst, input logic [31:0] alu,
                          input logic [31:0] sd, input logic [31:0] rdata, input int delay);
        logic        memop, mis, goes_mem, write;
        logic [31:0] exp_dat;
        memop    = rd || wr;
        mis      = memop && m_misal(sz, alu);
        goes_mem = memop && !mis;
        write    = rw && (dst != 0) && !wr && !mis;
        exp_dat  = (rd && !wr) ? m_load(rdata, alu, sz, uns) : alu;

        chk("pre_in_ready", in_ready, 1);
        drive(rd, wr, sz, uns, rw, dst, alu, sd);
        @(posedge clk); @(negedge clk);
        scramble_inputs();
        if (goes_mem) begin
            for (int i = 0; i <= delay; i++) begin
                chk("mem_req", dmem_req, 1);
                chk("mem_addr", dmem_addr, alu & ~32'd3);
                chk("mem_we", dmem_we, wr);
                chk("mem_be", dmem_be, m_be(alu, sz));
                if (wr) chk("mem_wdata", dmem_wdata, m_wdata(sd, sz));
                chk("mem_in_ready", in_ready, 0);
                chk("mem_RegWrite", RegWrite, 0);
                if (i == delay) begin dmem_ack = 1'b1; dmem_rdata = rdata; end
                @(posedge clk); @(negedge clk);
                dmem_ack = 1'b0; dmem_rdata = $urandom;
            end
        end
        chk("wb_dmem_req", dmem_req, 0);
        chk("wb_dmem_addr", dmem_addr, 0);
        chk("wb_dmem_be", dmem_be, 0);
        chk("wb_RegWrite", RegWrite, write);
        chk("wb_align_err", align_err, mis);
        chk("wb_in_ready", in_ready, 1);
        if (write) begin
            chk("wb_wr_reg", wr_reg, dst);
            chk("wb_wr_dat", wr_dat, exp_dat);
        end
        dmem_ack = 1'($urandom);
        @(posedge clk); @(negedge clk);
        dmem_ack = 1'b0;
        chk("post_RegWrite", RegWrite, 0);
        chk("post_align_err", align_err, 0);
        chk("post_dmem_req", dmem_req, 0);
        if (write) chk("post_wr_dat_hold", wr_dat, exp_dat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r_alu, r_sd, r_rd;
        logic [1:0]  r_sz;
        int          kind;

        rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        scramble_inputs();
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_dmem_wdata", dmem_wdata, 0);
        chk("rst_dmem_be", dmem_be, 0);
        chk("rst_wr_reg", wr_reg, 0);
        chk("rst_wr_dat", wr_dat, 0);
        chk("rst_RegWrite", RegWrite, 0);
        chk("rst_align_err", align_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back ALU stream, then a dst_reg=0 write.
        drive(1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd8, 32'h0000_0011, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("s1_RegWrite", RegWrite, 1); chk("s1_wr_reg", wr_reg, 8); chk("s1_wr_dat", wr_dat, 32'h11);
        chk("s1_in_ready", in_ready, 1);
        drive(1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd9, 32'h0000_0022, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("s2_RegWrite", RegWrite, 1); chk("s2_wr_reg", wr_reg, 9); chk("s2_wr_dat", wr_dat, 32'h22);
        drive(1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd10, 32'hDEAD_BEEF, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("s3_RegWrite", RegWrite, 1); chk("s3_wr_reg", wr_reg, 10); chk("s3_wr_dat", wr_dat, 32'hDEAD_BEEF);
        drive(1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd0, 32'h5555_5555, 32'd0);
        @(posedge clk); @(negedge clk);
        scramble_inputs();
        chk("r0_RegWrite", RegWrite, 0);
        @(posedge clk); @(negedge clk);
        chk("idle_RegWrite", RegWrite, 0);

        // Loads with sign/zero extension.
        run_op(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 5'd3, 32'h0000_1003, 32'd0, 32'h80FF_7F01, 1);
        chk("lb_literal", wr_dat, 32'hFFFF_FF80);
        run_op(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 5'd4, 32'h0000_1003, 32'd0, 32'h80FF_7F01, 0);
        chk("lbu_literal", wr_dat, 32'h0000_0080);
        run_op(1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 5'd5, 32'h0000_1002, 32'd0, 32'h80FF_7F01, 2);
        chk("lh_literal", wr_dat, 32'hFFFF_80FF);

        // Half store lane replication.
        run_op(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 5'd0, 32'h0000_0102, 32'h1234_ABCD, 32'd0, 0);

        // Long and zero-wait ack.
        run_op(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd12, 32'h0000_2000, 32'd0, 32'hCAFE_F00D, 5);
        run_op(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd13, 32'h0000_2004, 32'd0, 32'h0BAD_CAFE, 0);

        // Misaligned word load.
        run_op(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd14, 32'h0000_3006, 32'd0, 32'hFFFF_FFFF, 0);

        // Read+write together behaves as a store.
        run_op(1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 5'd15, 32'h0000_4001, 32'h0000_00A5, 32'd0, 1);

        // Asynchronous reset while in MEM.
        drive(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd7, 32'h0000_5000, 32'd0);
        @(posedge clk); @(negedge clk);
        scramble_inputs();
        chk("rmem_req_before", dmem_req, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rmem_req", dmem_req, 0);
        chk("rmem_addr", dmem_addr, 0);
        chk("rmem_RegWrite", RegWrite, 0);
        chk("rmem_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111;
        @(posedge clk); @(negedge clk);
        dmem_ack = 1'b0;
        chk("rrel_RegWrite", RegWrite, 0);
        chk("rrel_dmem_req", dmem_req, 0);
        chk("rrel_in_ready", in_ready, 1);
        chk("rrel_wr_dat", wr_dat, 0);

        // Randomized transactions.
        for (int n = 0; n < 80; n++) begin
            kind  = int'($urandom_range(0, 3));
            r_alu = $urandom;
            r_sd  = $urandom;
            r_rd  = $urandom;
            r_sz  = 2'($urandom);
            if ($urandom_range(0, 1) == 1) r_alu = r_alu & ~32'd3;
            run_op(kind == 1 || kind == 3, kind == 2 || kind == 3, r_sz, 1'($urandom),
                   ($urandom_range(0, 3) != 0), 5'($urandom), r_alu, r_sd, r_rd,
                   int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and write-back stage of the Lab 4 MIPS datapath. It accepts one executed instruction at a time from the EX stage and performs any load/store through a variable-latency data-memory handshake. It then drives the register file's write port (`wr_reg`, `wr_dat`, `RegWrite`) for exactly one cycle per committed write. It also handles byte/half/word lane alignment and load sign/zero extension.

## Interface
Parameters:
- none. Data width is fixed at 32 bits, register index at 5 bits.

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  EX stage presents an instruction
- `in_ready`  out  1  stage can accept this cycle
- `alu_result`  in  32  ALU output; memory address for loads/stores, write data otherwise
- `store_data`  in  32  rt value for stores
- `dst_reg`  in  5  destination register index
- `ctrl_regwrite`  in  1  instruction writes a register
- `MemRead`  in  1  load instruction
- `MemWrite`  in  1  store instruction
- `mem_size`  in  2  00 byte, 01 half, 10/11 word
- `mem_unsigned`  in  1  zero-extend loads (lbu/lhu)
- `dmem_req`  out  1  memory request, held until ack
- `dmem_we`  out  1  request is a write
- `dmem_addr`  out  32  word-aligned address ({alu_result[31:2],2'b00})
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_be`  out  4  byte enables
- `dmem_ack`  in  1  memory completes the request this cycle
- `dmem_rdata`  in  32  read data, valid when `dmem_ack`=1
- `wr_reg`  out  5  register-file write index
- `wr_dat`  out  32  register-file write data
- `RegWrite`  out  1  register-file write enable
- `align_err`  out  1  one-cycle pulse on a misaligned access

## Operation
- States are IDLE, MEM, and WB. `in_ready` = (state==IDLE) || (state==WB).
- Accept means `in_valid` && `in_ready` at a rising edge. On accept, all inputs are latched.
- Misalignment is a half access with addr[0]=1, or a word access with addr[1:0]≠0.
  - A misaligned access goes to WB with the write suppressed, `align_err`=1 in that WB cycle, and no memory request.
- An aligned load or store goes to MEM; all other instructions go to WB.
- MEM state:
  - `dmem_req`=1 and all `dmem_*` outputs are held stable.
  - The state leaves MEM on the edge where `dmem_ack`=1.
  - On that edge, a load captures the extracted data.
- WB state:
  - `RegWrite` = latched `ctrl_regwrite` && (`dst_reg`≠0) && !MemWrite && !misaligned.
  - `wr_dat` = extracted load data if MemRead, else `alu_result`.
  - From WB, the next state is IDLE, or the next target state if a new instruction is accepted the same edge.
- Both MemRead and MemWrite set: treated as a store, and `RegWrite` is forced 0.
- Load extraction is little-endian:
  - Byte: `dmem_rdata`[8*a[1:0] +: 8].
  - Half: a[1] ? [31:16] : [15:0].
  - Sign-extended unless `mem_unsigned`.
- Store lanes:
  - Byte: data replicated ×4, `dmem_be` = 4'b0001<<a[1:0].
  - Half: replicated ×2, `dmem_be` = a[1] ? 1100 : 0011.
  - Word: `dmem_be` = 1111.
- `dmem_ack` is ignored outside MEM.

## Timing
- Reset values: state=IDLE, so `in_ready`=1. All other outputs are 0, including `wr_reg`, `wr_dat`, `RegWrite`, `dmem_*`, and `align_err`.
- Non-memory op accepted at edge N: `RegWrite`=1 during cycle N+1 only.
- Back-to-back ALU ops sustain one per cycle.
- Memory op accepted at edge N: `dmem_req` rises in cycle N+1.
- Ack sampled at edge M: WB occurs in cycle M+1.
- Minimum load latency is two cycles after accept: ack in cycle N+1, write in N+2.
- `dmem_req` is never deasserted before ack. The `dmem_*` outputs return to 0 in the cycle after ack.
- `wr_reg` and `wr_dat` hold their last value after WB; only `RegWrite` drops.
- Async reset mid-MEM: `dmem_req` drops immediately, no write-back occurs, and the instruction is discarded.

## Test plan
- ALU stream: add results to regs 8, 9, 10 on consecutive cycles. Required: `RegWrite` high three consecutive cycles with `wr_dat` matching. `dst_reg`=0 gives `RegWrite`=0.
- lb with `dmem_rdata`=0x80FF_7F01, addr 0x...03. Required: `wr_dat`=0xFFFF_FF80. lbu gives 0x0000_0080. lh at addr 0x...2 gives 0xFFFF_80FF.
- sh of 0x1234_ABCD to addr 0x102. Required: `dmem_addr`=0x100, `dmem_be`=1100, `dmem_wdata`=0xABCD_ABCD, `RegWrite` stays 0.
- Ack delayed 5 cycles. Required: `dmem_req`/addr stable throughout, `in_ready`=0 during MEM, write-back exactly one cycle after ack. Zero-wait ack gives write at accept+2.
- lw at addr 0x...6. Required: no `dmem_req`, `align_err` pulses once, `RegWrite`=0.
- Assert `rst_n`=0 during MEM. Required: all outputs 0 immediately, `in_ready`=1 after release, no spurious write.
